// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle of stall-request, exception and control signals that
//               pass between the pipeline stages and the pipeline sequencer.
//               master = pipeline side (drives requests, consumes control)
//               slave  = sequencer side (pipe_ctrl)
// Signals     : stallreq_if/id/ex/mem - per-stage stall requests
//               excepttype_i          - MEM-stage exception type
//               cp0_epc_i             - current EPC from CP0
//               perf_clr              - synchronous clear of stall_cnt
//               stall[5:0]            - per-stage hold vector
//               flush                 - clear all pipeline registers
//               new_pc                - redirect PC, valid while flush=1
//               stall_timeout         - watchdog fire pulse
//               stall_cnt             - saturating stalled-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic        perf_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cnt;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excepttype_i, cp0_epc_i, perf_clr,
        input  stall, flush, new_pc, stall_timeout, stall_cnt
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excepttype_i, cp0_epc_i, perf_clr,
        output stall, flush, new_pc, stall_timeout, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Central sequencer for the 5-stage pipeline. Merges per-stage
//               stall requests into a 6-bit hold vector, sequences exception /
//               ERET / watchdog flushes with a redirect PC, masks new events
//               while the pipe refills, and counts stalled cycles.
// Ports       : clk  - clock
//               rst  - asynchronous reset, active-high
//               bus  - pipe_ctrl_if.slave (requests in, stall/flush/PC out)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
    parameter logic [31:0] TIMEOUT_VECTOR = 32'h0000_0040,
    parameter int unsigned STALL_TIMEOUT  = 1024,
    parameter int unsigned REFILL_CYCLES  = 3
) (
    input wire         clk,
    input wire         rst,
    pipe_ctrl_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int unsigned c_wd_w = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int unsigned c_rf_w = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(STALL_TIMEOUT - 1);
    localparam logic [c_rf_w-1:0] c_rf_last = c_rf_w'(REFILL_CYCLES - 1);

    localparam logic [31:0] c_exc_none = 32'h0000_0000;
    localparam logic [31:0] c_exc_eret = 32'h0000_000E;
    localparam logic [31:0] c_cnt_max  = 32'hFFFF_FFFF;

    localparam logic [5:0] c_stall_none = 6'b000000;
    localparam logic [5:0] c_stall_if   = 6'b000011;
    localparam logic [5:0] c_stall_id   = 6'b000111;
    localparam logic [5:0] c_stall_ex   = 6'b001111;
    localparam logic [5:0] c_stall_mem  = 6'b011111;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FLUSH  = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_wd_w-1:0]   r_wd_cnt;
    logic [c_rf_w-1:0]   r_refill_cnt;
    logic                r_flush;
    logic [31:0]         r_new_pc;
    logic                r_stall_timeout;
    logic [31:0]         r_stall_cnt;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic [5:0]  w_merged;
    logic        w_exc;
    logic        w_wd_hit;
    logic        w_trigger;
    logic [31:0] w_target;
    logic [5:0]  w_stall;

    // Highest requesting stage wins: holding a later stage implies holding
    // every earlier stage so nothing overruns the stalled instruction.
    always_comb begin
        w_merged = c_stall_none;
        if (bus.stallreq_mem) begin
            w_merged = c_stall_mem;
        end else if (bus.stallreq_ex) begin
            w_merged = c_stall_ex;
        end else if (bus.stallreq_id) begin
            w_merged = c_stall_id;
        end else if (bus.stallreq_if) begin
            w_merged = c_stall_if;
        end
    end

    assign w_exc     = (bus.excepttype_i != c_exc_none);
    assign w_wd_hit  = (r_wd_cnt == c_wd_last) && (w_merged != c_stall_none);
    assign w_trigger = (r_state == S_RUN) && (w_exc || w_wd_hit);

    // An exception always beats the watchdog for the redirect target.
    always_comb begin
        w_target = TIMEOUT_VECTOR;
        if (bus.excepttype_i == c_exc_eret) begin
            w_target = bus.cp0_epc_i;
        end else if (w_exc) begin
            w_target = EXC_VECTOR;
        end
    end

    // Stall depends only on state and current inputs. On a trigger cycle the
    // MEM stage is held while mem_wb is released, so mem_wb loads a bubble and
    // the faulting instruction never writes back.
    always_comb begin
        w_stall = c_stall_none;
        if (rst) begin
            w_stall = c_stall_none;
        end else begin
            case (r_state)
                S_RUN:    w_stall = w_trigger ? c_stall_mem : w_merged;
                S_REFILL: w_stall = w_merged;
                default:  w_stall = c_stall_none;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer: RUN -> FLUSH (1 cycle) -> REFILL (REFILL_CYCLES) -> RUN
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_RUN;
            r_wd_cnt        <= '0;
            r_refill_cnt    <= '0;
            r_flush         <= 1'b0;
            r_new_pc        <= 32'h0000_0000;
            r_stall_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_trigger) begin
                        r_state         <= S_FLUSH;
                        r_flush         <= 1'b1;
                        r_new_pc        <= w_target;
                        r_stall_timeout <= !w_exc;
                        r_wd_cnt        <= '0;
                    end else if (w_merged != c_stall_none) begin
                        // Cannot pass c_wd_last here: reaching it with a stall
                        // pending is a trigger.
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end else begin
                        r_wd_cnt <= '0;
                    end
                end

                S_FLUSH: begin
                    r_state         <= S_REFILL;
                    r_flush         <= 1'b0;
                    r_stall_timeout <= 1'b0;
                    r_refill_cnt    <= '0;
                    r_wd_cnt        <= '0;
                end

                S_REFILL: begin
                    // Exceptions and the watchdog are masked while the
                    // freshly redirected instructions refill the pipe.
                    r_wd_cnt <= '0;
                    if (r_refill_cnt == c_rf_last) begin
                        r_state <= S_RUN;
                    end else begin
                        r_refill_cnt <= r_refill_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state         <= S_RUN;
                    r_flush         <= 1'b0;
                    r_stall_timeout <= 1'b0;
                    r_wd_cnt        <= '0;
                    r_refill_cnt    <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stalled-cycle performance counter (counts the PC hold bit, so trigger
    // cycles are included). Clear has priority over increment.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 32'h0000_0000;
        end else if (bus.perf_clr) begin
            r_stall_cnt <= 32'h0000_0000;
        end else if (w_stall[0] && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 32'h0000_0001;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.stall         = w_stall;
    assign bus.flush         = r_flush;
    assign bus.new_pc        = r_new_pc;
    assign bus.stall_timeout = r_stall_timeout;
    assign bus.stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire
